// File: rtl/bram_loader.sv
// Loads a UART byte stream into a byte-wide BRAM until a terminator byte or memory-full.
// Optional echo of accepted bytes to the UART transmitter: define BRAM_LOADER_ECHO_EN.
module bram_loader #(
  parameter int         AddrBits   = 19,
  parameter int         Words      = 2**AddrBits,
  parameter logic [7:0] Terminator = 8'h00
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [7:0]          RXDAT,
  input  logic                RXSTB,
  input  logic                START,
  output logic [AddrBits-1:0] ADDR,
  output logic                WR,
  output logic [7:0]          DOUT,
  output logic                BUSY,
  output logic                DONE,
  output logic                OVF,
  output logic [AddrBits-1:0] LEN,
  output logic [7:0]          TXDAT,
  output logic                TXSTB,
  input  logic                TXRDY
);

  localparam logic [1:0] SIdle = 2'd0;
  localparam logic [1:0] SLoad = 2'd1;
  localparam logic [1:0] SDone = 2'd2;

  localparam logic [AddrBits-1:0] LastPtr = AddrBits'(Words - 1);
  localparam logic [AddrBits-1:0] One     = AddrBits'(1);

  logic [1:0]          state_q, state_d;
  logic [AddrBits-1:0] ptr_q, ptr_d;
  logic [AddrBits-1:0] addr_q, addr_d;
  logic [7:0]          dout_q, dout_d;
  logic                wr_q, wr_d;
  logic [AddrBits-1:0] len_q, len_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    wr_d    = 1'b0;
    len_d   = len_q;
    ovf_d   = ovf_q;
    accept  = 1'b0;

    // START wins over a coincident RXSTB, so a strobe in that cycle is dropped.
    if (START) begin
      ptr_d   = '0;
      len_d   = '0;
      ovf_d   = 1'b0;
      state_d = SLoad;
    end else if (state_q == SLoad && RXSTB) begin
      accept = 1'b1;
      addr_d = ptr_q;
      dout_d = RXDAT;
      wr_d   = 1'b1;
      ptr_d  = (ptr_q == LastPtr) ? ptr_q : ptr_q + One;
      if (RXDAT == Terminator) begin
        state_d = SDone;
      end else begin
        len_d = len_q + One;
        if (ptr_q == LastPtr) begin
          ovf_d   = 1'b1;
          state_d = SDone;
        end
      end
    end else if (state_q != SIdle && state_q != SLoad && state_q != SDone) begin
      state_d = SIdle;
    end

    busy_d = (state_d == SLoad);
    done_d = (state_d == SDone);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= SIdle;
      ptr_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      wr_q    <= 1'b0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ADDR = addr_q;
  assign WR   = wr_q;
  assign DOUT = dout_q;
  assign LEN  = len_q;
  assign OVF  = ovf_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

`ifdef BRAM_LOADER_ECHO_EN
  logic [7:0] txdat_q, txdat_d;
  logic       txstb_q, txstb_d;

  // A fresh byte overrides the handshake clear, keeping TXSTB high.
  always_comb begin
    txdat_d = txdat_q;
    txstb_d = txstb_q & ~TXRDY;
    if (accept) begin
      txdat_d = RXDAT;
      txstb_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      txdat_q <= '0;
      txstb_q <= 1'b0;
    end else begin
      txdat_q <= txdat_d;
      txstb_q <= txstb_d;
    end
  end

  assign TXDAT = txdat_q;
  assign TXSTB = txstb_q;
`else
  logic [1:0] unused_echo;
  assign unused_echo = {TXRDY, accept};
  assign TXDAT       = 8'h00;
  assign TXSTB       = 1'b0;
`endif

endmodule
